run_detect_sched: RTL

//  Time-multiplexed scheduler for a shared consecutive-ones run detector.
//  NCH serial channels compete for one detection engine. A round-robin arbiter

---
 rtl/run_detect_pkg.sv | 23 ++
 rtl/run_detect_sched_rr_arbiter.sv | 44 ++++
 rtl/run_detect_sched.sv | 121 ++++++++++++
 3 files changed

// File: rtl/run_detect_pkg.sv
// run_detect_pkg
//   Shared constants and helpers for the run_detect_sched scheduler and its
//   round-robin arbiter.
//   - EVT_CNT_W / EVT_CNT_MAX : width and saturation value of the optional
//     per-channel detection counters.
//   - clog2_min1 : channel-index width, never less than one bit.
//   - rr_next    : round-robin pointer update.
package run_detect_pkg;

  localparam int                   EVT_CNT_W   = 8;
  localparam logic [EVT_CNT_W-1:0] EVT_CNT_MAX = 8'hFF;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // A value of g outside 0..nch-1 means "no grant this cycle": the pointer holds.
  function automatic int rr_next(input int ptr, input int g, input int nch);
    if (g >= nch) return ptr;
    return (g + 1) % nch;
  endfunction

endpackage

// File: rtl/run_detect_sched_rr_arbiter.sv
// rr_arbiter
//   Combinational round-robin arbiter. Picks the first requesting channel
//   scanning ptr, ptr+1, ... modulo NCH. The pointer register lives in the
//   parent.
// Ports
//   req     in  NCH  request vector
//   ptr     in  CHW  highest-priority channel this cycle
//   gnt     out NCH  one-hot grant (all zero when req == 0)
//   g       out CHW  index of the granted channel (0 when no grant)
//   gnt_any out 1    a grant was issued
module rr_arbiter
  import run_detect_pkg::*;
#(
  parameter  int NCH = 4,
  localparam int CHW = clog2_min1(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [CHW-1:0] ptr,
  output logic [NCH-1:0] gnt,
  output logic [CHW-1:0] g,
  output logic           gnt_any
);

  logic [CHW-1:0] sel;

  // Walk from the lowest priority to the highest so the last hit, i.e. the
  // one closest to ptr, is the one that sticks.
  always_comb begin
    gnt     = '0;
    g       = '0;
    gnt_any = 1'b0;
    sel     = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      sel = CHW'((int'(ptr) + k) % NCH);
      if (req[sel]) begin
        gnt      = '0;
        gnt[sel] = 1'b1;
        g        = sel;
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/run_detect_sched.sv
// run_detect_sched
//   Time-multiplexed scheduler for one shared consecutive-ones run detector.
//   NCH serial channels are served round-robin, one per clock; each channel
//   keeps its own saturating run-length context, so a run split across
//   non-adjacent grants is still detected.
// Ports
//   clock    in  1    rising-edge clock
//   reset    in  1    asynchronous, active-low
//   req      in  NCH  channel i has a bit pending on bit_in[i]
//   bit_in   in  NCH  serial data, stable while req[i]=1
//   gnt      out NCH  one-hot combinational grant; bit consumed at the next edge
//   y_out    out NCH  registered; 1 while channel run >= THRESH
//   y_valid  out 1    registered pulse: a context was updated at the last edge
//   y_ch     out CHW  channel updated at the last edge
//   busy     out 1    |req
//   sel_ch   in  CHW  (DETECT_CNT_EN) channel select for evt_cnt
//   evt_cnt  out 8    (DETECT_CNT_EN) saturating count of y_out rises on sel_ch
// Build option
//   DETECT_CNT_EN : adds per-channel detection counters, sel_ch and evt_cnt.
module run_detect_sched
  import run_detect_pkg::*;
#(
  parameter  int NCH    = 4,
  parameter  int THRESH = 3,
  localparam int CHW    = clog2_min1(NCH),
  localparam int CW     = $clog2(THRESH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NCH-1:0]       req,
  input  logic [NCH-1:0]       bit_in,
  output logic [NCH-1:0]       gnt,
  output logic [NCH-1:0]       y_out,
  output logic                 y_valid,
  output logic [CHW-1:0]       y_ch,
  output logic                 busy
`ifdef DETECT_CNT_EN
  ,
  input  logic [CHW-1:0]       sel_ch,
  output logic [EVT_CNT_W-1:0] evt_cnt
`endif
);

  localparam logic [CW-1:0] THR = CW'(THRESH);

  logic [CHW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  run_q [NCH];
  logic [CW-1:0]  run_d;
  logic [NCH-1:0] y_out_q, y_out_d;
  logic           y_valid_q;
  logic [CHW-1:0] y_ch_q;

  logic [NCH-1:0] arb_gnt;
  logic [CHW-1:0] arb_g;
  logic           arb_any;
  logic           take;

  rr_arbiter #(.NCH(NCH)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .gnt     (arb_gnt),
    .g       (arb_g),
    .gnt_any (arb_any)
  );

  // No bit may be consumed while reset is held, so the grant is masked too.
  assign take    = arb_any & reset;
  assign gnt     = reset ? arb_gnt : '0;
  assign busy    = |req;
  assign y_out   = y_out_q;
  assign y_valid = y_valid_q;
  assign y_ch    = y_ch_q;

  always_comb begin
    run_d = '0;
    if (bit_in[arb_g]) begin
      run_d = (run_q[arb_g] == THR) ? THR : run_q[arb_g] + CW'(1);
    end
    y_out_d = y_out_q;
    if (take) y_out_d[arb_g] = (run_d == THR);
    ptr_d = CHW'(rr_next(int'(ptr_q), take ? int'(arb_g) : NCH, NCH));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_q     <= '0;
      y_out_q   <= '0;
      y_valid_q <= 1'b0;
      y_ch_q    <= '0;
      for (int i = 0; i < NCH; i++) run_q[i] <= '0;
    end else begin
      ptr_q     <= ptr_d;
      y_out_q   <= y_out_d;
      y_valid_q <= take;
      if (take) begin
        run_q[arb_g] <= run_d;
        y_ch_q       <= arb_g;
      end
    end
  end

`ifdef DETECT_CNT_EN
  logic [EVT_CNT_W-1:0] cnt_q [NCH];

  // Count at the same edge that raises y_out, using its next-state value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (y_out_d[i] && !y_out_q[i] && (cnt_q[i] != EVT_CNT_MAX)) begin
          cnt_q[i] <= cnt_q[i] + EVT_CNT_W'(1);
        end
      end
    end
  end

  assign evt_cnt = cnt_q[sel_ch];
`endif

endmodule
